// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the comparator and its arbiter: register width,
// comparison opcodes and the highest legal opcode value.
package cmp_arbiter_pkg;

  localparam int unsigned REG_LEN    = 32;
  localparam int unsigned CMP_OP_MAX = 5;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5
  } cmp_op_e;

endpackage

// File: rtl/cmp_arbiter_cmp.sv
// Combinational comparator. Opcodes above CMP_OP_MAX produce 0.
module cmp
  import cmp_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = REG_LEN,
  parameter int unsigned OP_W   = 3
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic              res
);

  // Evaluate the selected relation; signed ops use two's complement.
  always_comb begin
    res = 1'b0;
    case (op)
      OP_W'(CMP_EQ):  res = (a == b);
      OP_W'(CMP_NE):  res = (a != b);
      OP_W'(CMP_LT):  res = ($signed(a) <  $signed(b));
      OP_W'(CMP_GE):  res = ($signed(a) >= $signed(b));
      OP_W'(CMP_LTU): res = (a <  b);
      OP_W'(CMP_GEU): res = (a >= b);
      default:        res = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator between branch resolution
// (requester 0) and the ALU SLT/SLTU path (requester 1). The 1-bit result
// is held in a single-entry response slot tagged with its owner.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = REG_LEN,
  parameter int unsigned OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_rs1,
  input  logic [DATA_W-1:0] req0_rs2,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_rs1,
  input  logic [DATA_W-1:0] req1_rs2,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic              rsp_b,
  output logic              rsp_illegal
);

  logic rsp0_valid_q, rsp0_valid_d;
  logic rsp1_valid_q, rsp1_valid_d;
  logic rsp_b_q, rsp_b_d;
  logic rsp_illegal_q, rsp_illegal_d;
  logic owner_q, owner_d;
  logic last_gnt_q, last_gnt_d;

  logic              grant;
  logic              full;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] sel_rs1;
  logic [DATA_W-1:0] sel_rs2;
  logic [OP_W-1:0]   sel_op;
  logic              cmp_res;

  // Round-robin grant, slot availability and operand mux.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_gnt_q;
    else if (req1_valid)          grant = 1'b1;
    full       = rsp0_valid_q | rsp1_valid_q;
    can_accept = ~full | (~owner_q & rsp0_ready) | (owner_q & rsp1_ready);
    req0_ready = can_accept & ~grant & req0_valid;
    req1_ready = can_accept &  grant & req1_valid;
    accept     = req0_ready | req1_ready;
    sel_rs1    = grant ? req1_rs1 : req0_rs1;
    sel_rs2    = grant ? req1_rs2 : req0_rs2;
    sel_op     = grant ? req1_op  : req0_op;
  end

  cmp #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_cmp (
    .a   (sel_rs1),
    .b   (sel_rs2),
    .op  (sel_op),
    .res (cmp_res)
  );

  // Next slot contents: refill on accept, otherwise empty when the owner drains.
  always_comb begin
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp_b_d       = rsp_b_q;
    rsp_illegal_d = rsp_illegal_q;
    owner_d       = owner_q;
    last_gnt_d    = last_gnt_q;
    if (accept) begin
      rsp0_valid_d  = ~grant;
      rsp1_valid_d  =  grant;
      rsp_b_d       = cmp_res;
      rsp_illegal_d = (sel_op > OP_W'(CMP_OP_MAX));
      owner_d       = grant;
      last_gnt_d    = grant;
    end else if (full && can_accept) begin
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
    end
  end

  // Response slot and round-robin state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp_b_q       <= 1'b0;
      rsp_illegal_q <= 1'b0;
      owner_q       <= 1'b0;
      last_gnt_q    <= 1'b1;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp_b_q       <= rsp_b_d;
      rsp_illegal_q <= rsp_illegal_d;
      owner_q       <= owner_d;
      last_gnt_q    <= last_gnt_d;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp_b       = rsp_b_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule
